// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared pipeline types: forwarding-source encoding and the
//               default register-number width.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int REG_W_DEF = 5;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,   // operand comes from the register file
        FWD_E  = 2'd1,   // E-stage ALU result
        FWD_M  = 2'd2,   // M-stage data / memory output
        FWD_W  = 2'd3    // W-stage write-back data
    } fwd_sel_e;

endpackage
`default_nettype wire

// File: rtl/md_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : md_scoreboard
// Description : Single-entry countdown scoreboard for an in-flight multi-cycle
//               multiply/divide result. Reports busy, the write-back cycle and
//               per-query register matches against the pending destination.
// Revision    : 1.0 - initial release
// ============================================================================
module md_scoreboard
    import pipe_pkg::*;
#(
    parameter int REG_W      = REG_W_DEF,
    parameter int MD_LATENCY = 4,
    parameter int NQ         = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  accept_i,
    input  logic [REG_W-1:0]      rd_i,
    input  logic [NQ*REG_W-1:0]   q_rn_i,
    input  logic [NQ-1:0]         q_vld_i,
    output logic                  busy_o,
    output logic                  wb_o,
    output logic [NQ-1:0]         hit_o
);

    localparam int CNT_W = $clog2(MD_LATENCY + 1);

    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic [REG_W-1:0] md_rd_q,  md_rd_d;

    // True when rn names a real register (not r0) equal to the pending target.
    function automatic logic rn_match(input logic [REG_W-1:0] rn,
                                      input logic [REG_W-1:0] tgt);
        return (rn != '0) && (rn == tgt);
    endfunction

    assign busy_o = (md_cnt_q != '0);
    assign wb_o   = (md_cnt_q == CNT_W'(1));

    // Reload on accept; otherwise count down while an entry is pending.
    always_comb begin
        md_cnt_d = md_cnt_q;
        md_rd_d  = md_rd_q;
        if (accept_i) begin
            md_cnt_d = CNT_W'(MD_LATENCY);
            md_rd_d  = rd_i;
        end else if (busy_o) begin
            md_cnt_d = md_cnt_q - CNT_W'(1);
        end
    end

    // Scoreboard state; reset drops any pending entry without a write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt_q <= '0;
            md_rd_q  <= '0;
        end else begin
            md_cnt_q <= md_cnt_d;
            md_rd_q  <= md_rd_d;
        end
    end

    for (genvar k = 0; k < NQ; k++) begin : g_query
        assign hit_o[k] = busy_o && q_vld_i[k] &&
                          rn_match(q_rn_i[k*REG_W +: REG_W], md_rd_q);
    end

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard_cu.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard_cu
// Description : Hazard/forwarding control for the 5-stage pipe: operand
//               forwarding, load-use stalls, MD scoreboard interlocks, memory
//               wait freeze and E-stage redirect kill of the D instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard_cu
    import pipe_pkg::*;
#(
    parameter int REG_W      = REG_W_DEF,
    parameter int NUM_SRC    = 2,
    parameter int MD_LATENCY = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_SRC*REG_W-1:0] d_src_rn_i,
    input  logic [NUM_SRC-1:0]       d_need_i,
    input  logic                     d_wreg_i,
    input  logic [REG_W-1:0]         d_rn_i,
    input  logic                     d_md_start_i,
    input  logic [REG_W-1:0]         d_md_rd_i,
    input  logic                     e_wreg_i,
    input  logic                     e_m2reg_i,
    input  logic [REG_W-1:0]         e_rn_i,
    input  logic                     m_wreg_i,
    input  logic                     m_m2reg_i,
    input  logic [REG_W-1:0]         m_rn_i,
    input  logic                     w_wreg_i,
    input  logic [REG_W-1:0]         w_rn_i,
    input  logic                     e_redirect_i,
    input  logic                     m_mem_ready_i,
    output logic [NUM_SRC*2-1:0]     fwd_sel_o,
    output logic                     f_stall_o,
    output logic                     d_stall_o,
    output logic                     d_bubble_o,
    output logic                     e_stall_o,
    output logic                     e_bubble_o,
    output logic                     m_stall_o,
    output logic                     m_bubble_o,
    output logic                     w_stall_o,
    output logic                     w_bubble_o,
    output logic                     md_accept_o,
    output logic                     md_busy_o,
    output logic                     md_wb_o
);

    logic [NUM_SRC-1:0] w_luse_vec;
    logic [NUM_SRC:0]   w_md_hit;
    logic               w_luse, w_md_hz, w_md_struct, w_hold;

    // M's load/ALU distinction does not matter: its data is selectable either way.
    logic               w_m_m2reg_unused;
    assign w_m_m2reg_unused = m_m2reg_i;

    function automatic logic rn_match(input logic [REG_W-1:0] a,
                                      input logic [REG_W-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [REG_W-1:0] w_rn;
        fwd_sel_e         w_fwd;
        assign w_rn = d_src_rn_i[i*REG_W +: REG_W];

        // Youngest producing stage wins; a load in E cannot forward yet.
        always_comb begin
            w_fwd = FWD_RF;
            if (d_need_i[i]) begin
                if (e_wreg_i && !e_m2reg_i && rn_match(w_rn, e_rn_i))
                    w_fwd = FWD_E;
                else if (m_wreg_i && rn_match(w_rn, m_rn_i))
                    w_fwd = FWD_M;
                else if (w_wreg_i && rn_match(w_rn, w_rn_i))
                    w_fwd = FWD_W;
            end
        end

        assign fwd_sel_o[i*2 +: 2] = w_fwd;
        assign w_luse_vec[i] = d_need_i[i] && e_wreg_i && e_m2reg_i &&
                               rn_match(w_rn, e_rn_i);
    end

    // Queries: source operands (RAW) plus the D destination (WAW) on top.
    md_scoreboard #(
        .REG_W      (REG_W),
        .MD_LATENCY (MD_LATENCY),
        .NQ         (NUM_SRC + 1)
    ) u_md_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .accept_i (md_accept_o),
        .rd_i     (d_md_rd_i),
        .q_rn_i   ({d_rn_i, d_src_rn_i}),
        .q_vld_i  ({d_wreg_i, d_need_i}),
        .busy_o   (md_busy_o),
        .wb_o     (md_wb_o),
        .hit_o    (w_md_hit)
    );

    assign w_luse      = |w_luse_vec;
    assign w_md_hz     = |w_md_hit;
    assign w_md_struct = d_md_start_i && md_busy_o;
    assign w_hold      = w_luse || w_md_hz || w_md_struct;
    assign md_accept_o = d_md_start_i && !w_hold && m_mem_ready_i;

    // Memory wait freezes everything; otherwise hold, with redirect killing D.
    always_comb begin
        f_stall_o  = 1'b0;
        d_stall_o  = 1'b0;
        d_bubble_o = 1'b0;
        e_stall_o  = 1'b0;
        e_bubble_o = 1'b0;
        m_stall_o  = 1'b0;
        m_bubble_o = 1'b0;
        w_stall_o  = 1'b0;
        w_bubble_o = 1'b0;
        if (!m_mem_ready_i) begin
            f_stall_o  = 1'b1;
            d_stall_o  = 1'b1;
            e_stall_o  = 1'b1;
            m_stall_o  = 1'b1;
            w_bubble_o = 1'b1;
        end else if (w_hold) begin
            e_bubble_o = 1'b1;
            if (e_redirect_i) begin
                d_bubble_o = 1'b1;
            end else begin
                f_stall_o = 1'b1;
                d_stall_o = 1'b1;
            end
        end else if (e_redirect_i) begin
            d_bubble_o = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard_cu.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard_cu
// Description : Self-checking bench for hazard_scoreboard_cu: directed
//               scenarios plus randomized traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard_cu;

    localparam int RW  = 5;
    localparam int NS  = 2;
    localparam int LAT = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NS*RW-1:0]  d_src_rn;
    logic [NS-1:0]     d_need;
    logic              d_wreg, d_md_start, e_wreg, e_m2reg, m_wreg, m_m2reg;
    logic              w_wreg, e_redirect, m_mem_ready;
    logic [RW-1:0]     d_rn, d_md_rd, e_rn, m_rn, w_rn;
    logic [NS*2-1:0]   fwd_sel;
    logic              f_stall, d_stall, d_bubble, e_stall, e_bubble;
    logic              m_stall, m_bubble, w_stall, w_bubble;
    logic              md_accept, md_busy, md_wb;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: the MD op is described by its accept cycle, not a counter.
    int        cyc = 0;
    bit        md_v = 1'b0;
    int        md_t = 0;
    logic [RW-1:0] md_r = '0;

    // Expected values for the current cycle.
    logic [NS*2-1:0] x_fwd;
    logic [8:0]      x_stl;
    logic            x_acc, x_busy, x_wb;

    hazard_scoreboard_cu #(.REG_W(RW), .NUM_SRC(NS), .MD_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .d_src_rn_i(d_src_rn), .d_need_i(d_need), .d_wreg_i(d_wreg), .d_rn_i(d_rn),
        .d_md_start_i(d_md_start), .d_md_rd_i(d_md_rd),
        .e_wreg_i(e_wreg), .e_m2reg_i(e_m2reg), .e_rn_i(e_rn),
        .m_wreg_i(m_wreg), .m_m2reg_i(m_m2reg), .m_rn_i(m_rn),
        .w_wreg_i(w_wreg), .w_rn_i(w_rn),
        .e_redirect_i(e_redirect), .m_mem_ready_i(m_mem_ready),
        .fwd_sel_o(fwd_sel),
        .f_stall_o(f_stall), .d_stall_o(d_stall), .d_bubble_o(d_bubble),
        .e_stall_o(e_stall), .e_bubble_o(e_bubble),
        .m_stall_o(m_stall), .m_bubble_o(m_bubble),
        .w_stall_o(w_stall), .w_bubble_o(w_bubble),
        .md_accept_o(md_accept), .md_busy_o(md_busy), .md_wb_o(md_wb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic idle();
        d_src_rn = '0; d_need = '0; d_wreg = 0; d_rn = '0;
        d_md_start = 0; d_md_rd = '0;
        e_wreg = 0; e_m2reg = 0; e_rn = '0;
        m_wreg = 0; m_m2reg = 0; m_rn = '0;
        w_wreg = 0; w_rn = '0;
        e_redirect = 0; m_mem_ready = 1;
    endtask

    // Evaluate the pipeline rules directly from the current inputs.
    task automatic model();
        bit luse, hz, hold, f, d, db, e, eb, m, w, wb;
        logic [RW-1:0] rn;
        x_busy = rst_n && md_v && (cyc > md_t) && (cyc <= md_t + LAT);
        x_wb   = rst_n && md_v && (cyc == md_t + LAT);
        luse = 0; hz = 0;
        for (int i = 0; i < NS; i++) begin
            rn = d_src_rn[i*RW +: RW];
            x_fwd[i*2 +: 2] = 2'd0;
            if (d_need[i] && rn != 0) begin
                if (e_wreg && !e_m2reg && rn == e_rn) x_fwd[i*2 +: 2] = 2'd1;
                else if (m_wreg && rn == m_rn)        x_fwd[i*2 +: 2] = 2'd2;
                else if (w_wreg && rn == w_rn)        x_fwd[i*2 +: 2] = 2'd3;
                if (e_wreg && e_m2reg && rn == e_rn) luse = 1;
                if (x_busy && rn == md_r) hz = 1;
            end
        end
        if (x_busy && d_wreg && d_rn != 0 && d_rn == md_r) hz = 1;
        hold  = luse || hz || (d_md_start && x_busy);
        x_acc = d_md_start && !hold && m_mem_ready;
        {f, d, db, e, eb, m, w, wb} = '0;
        if (!m_mem_ready) begin
            f = 1; d = 1; e = 1; m = 1; wb = 1;
        end else if (hold) begin
            eb = 1;
            if (e_redirect) db = 1; else begin f = 1; d = 1; end
        end else if (e_redirect) db = 1;
        x_stl = {f, d, db, e, eb, m, 1'b0, w, wb};
    endtask

    task automatic check_all();
        model();
        chk("fwd_sel", 32'(fwd_sel), 32'(x_fwd));
        chk("stall_bubble", 32'({f_stall, d_stall, d_bubble, e_stall, e_bubble,
                                 m_stall, m_bubble, w_stall, w_bubble}), 32'(x_stl));
        chk("md_accept", 32'(md_accept), 32'(x_acc));
        chk("md_busy", 32'(md_busy), 32'(x_busy));
        chk("md_wb", 32'(md_wb), 32'(x_wb));
    endtask

    // One clock: check mid-cycle, then advance the model with the edge.
    task automatic tick();
        @(negedge clk);
        check_all();
        @(posedge clk);
        if (rst_n && x_acc) begin
            md_v = 1; md_t = cyc; md_r = d_md_rd;
        end
        cyc++;
        #1;
    endtask

    initial begin
        int t0;
        idle();
        rst_n = 0;
        #2;
        chk("rst_md_busy", 32'(md_busy), 0);
        chk("rst_md_wb", 32'(md_wb), 0);
        tick();
        rst_n = 1;
        tick();

        // Forwarding priority E > M > W > RF, and r0 never forwards.
        d_src_rn = {5'd0, 5'd3}; d_need = 2'b11;
        e_wreg = 1; e_rn = 3; m_wreg = 1; m_rn = 3; w_wreg = 1; w_rn = 3;
        #1 chk("fwd_e", 32'(fwd_sel[1:0]), 1); chk("fwd_r0", 32'(fwd_sel[3:2]), 0);
        tick();
        e_wreg = 0;
        #1 chk("fwd_m", 32'(fwd_sel[1:0]), 2);
        tick();
        m_wreg = 0;
        #1 chk("fwd_w", 32'(fwd_sel[1:0]), 3);
        tick();

        // Load-use on operand 1, then forward from M next cycle.
        idle();
        d_src_rn = {5'd5, 5'd0}; d_need = 2'b10;
        e_wreg = 1; e_m2reg = 1; e_rn = 5;
        #1 chk("luse_stall", 32'({f_stall, d_stall, e_bubble}), 32'h7);
        tick();
        e_wreg = 0; e_m2reg = 0; m_wreg = 1; m_m2reg = 1; m_rn = 5;
        #1 chk("luse_fwd_m", 32'(fwd_sel[3:2]), 2); chk("luse_nostall", 32'(d_stall), 0);
        tick();

        // MD to r7, RAW reader stalls through T+LAT, WAW at T+2.
        idle();
        d_md_start = 1; d_md_rd = 7;
        #1 chk("md_acc", 32'(md_accept), 1);
        t0 = cyc;
        tick();
        idle();
        for (int k = 1; k <= LAT; k++) begin
            d_src_rn = {5'd0, 5'd7}; d_need = 2'b01;
            d_wreg = (k == 2); d_rn = 7;
            #1 chk("md_raw_stall", 32'(d_stall), 1);
            chk("md_wb_sched", 32'(md_wb), 32'(cyc == t0 + LAT));
            tick();
        end
        #1 chk("md_release", 32'(d_stall), 0);
        tick();

        // Back-to-back MD: second one waits for the countdown, mem wait mid-way.
        idle();
        d_md_start = 1; d_md_rd = 9;
        t0 = cyc;
        tick();
        for (int k = 1; k <= LAT; k++) begin
            d_md_rd = 10;
            m_mem_ready = !(k >= 2 && k <= 4);
            #1 chk("md2_blocked", 32'(md_accept), 0);
            if (!m_mem_ready) chk("memwait_stall", 32'({f_stall, d_stall, e_stall,
                                                         m_stall, w_bubble}), 32'h1f);
            tick();
        end
        m_mem_ready = 1;
        #1 chk("md2_accept", 32'(md_accept), 1);
        tick();

        // Hold together with redirect, then reset in the middle of the MD op.
        idle();
        d_src_rn = {5'd0, 5'd5}; d_need = 2'b01;
        e_wreg = 1; e_m2reg = 1; e_rn = 5; e_redirect = 1;
        #1 chk("redir_hold", 32'({d_bubble, d_stall, e_bubble, f_stall}), 32'ha);
        tick();
        idle();
        rst_n = 0;
        #1 chk("async_rst_busy", 32'(md_busy), 0);
        md_v = 0;
        tick();
        rst_n = 1;
        for (int k = 0; k < LAT + 1; k++) tick();

        // Randomized traffic over a small register range to force collisions.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NS; i++) d_src_rn[i*RW +: RW] = RW'($urandom_range(0, 7));
            d_need     = NS'($urandom);
            d_wreg     = 1'($urandom);  d_rn    = RW'($urandom_range(0, 7));
            d_md_start = ($urandom_range(0, 3) == 0);
            d_md_rd    = RW'($urandom_range(0, 7));
            e_wreg     = 1'($urandom);  e_m2reg = 1'($urandom); e_rn = RW'($urandom_range(0, 7));
            m_wreg     = 1'($urandom);  m_m2reg = 1'($urandom); m_rn = RW'($urandom_range(0, 7));
            w_wreg     = 1'($urandom);  w_rn    = RW'($urandom_range(0, 7));
            e_redirect = ($urandom_range(0, 7) == 0);
            m_mem_ready = ($urandom_range(0, 7) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
